// File: rtl/down_timer.sv
// Five-bit down-counting timer with load, start, pause and stop controls.
// Defining AUTO_RELOAD_EN makes the timer restart from its reload value after each terminal count.
module down_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] data,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    output logic [4:0] count,
    output logic       busy,
    output logic       zero,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] count_q, count_d;
    logic [4:0] reload_q, reload_d;
    logic       done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            reload_q <= 5'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Controls resolve as stop > load > start > pause > decrement; DONE ignores them all.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        case (state_q)
            IDLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (load) begin
                    count_d  = data;
                    reload_d = data;
                    if (start) begin
                        state_d = (data != 5'd0) ? RUN : DONE;
                    end
                end else if (start) begin
                    state_d = (count_q != 5'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (load) begin
                    count_d  = data;
                    reload_d = data;
                    state_d  = (data != 5'd0) ? RUN : DONE;
                end else if (!pause) begin
                    if (count_q != 5'd0) begin
                        count_d = count_q - 5'd1;
                    end
                    if (count_q <= 5'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
`ifdef AUTO_RELOAD_EN
                if (reload_q != 5'd0) begin
                    state_d = RUN;
                    count_d = reload_q;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // done is registered alongside state so it is high exactly while the state is DONE.
    always_comb begin
        done_d = (state_d == DONE);
    end

    always_comb begin
        count = count_q;
        busy  = (state_q == RUN);
        zero  = (count_q == 5'd0);
        done  = done_q;
    end

endmodule

// File: tb/tb_down_timer.sv
// Directed scoreboard bench for down_timer: each step queues its expected outputs,
// which are popped and compared one cycle later.
module tb_down_timer;

    logic       clk;
    logic       rst;
    logic [4:0] data;
    logic       load;
    logic       start;
    logic       pause;
    logic       stop;
    logic [4:0] count;
    logic       busy;
    logic       zero;
    logic       done;

    typedef struct {
        string      tag;
        logic [4:0] count;
        logic       busy;
        logic       done;
    } expect_t;

    expect_t scoreboard[$];
    int      vectors     = 0;
    int      miscompares = 0;

    down_timer dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .load  (load),
        .start (start),
        .pause (pause),
        .stop  (stop),
        .count (count),
        .busy  (busy),
        .zero  (zero),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input string tag, input logic r, input logic [4:0] d,
                                 input logic l, input logic s, input logic p, input logic sp,
                                 input logic [4:0] ec, input logic eb, input logic ed);
        expect_t e;
        rst   = r;
        data  = d;
        load  = l;
        start = s;
        pause = p;
        stop  = sp;
        e.tag   = tag;
        e.count = ec;
        e.busy  = eb;
        e.done  = ed;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput();
        expect_t e;
        logic    ez;
        e  = scoreboard.pop_front();
        ez = (e.count == 5'd0);
        vectors++;
        assert (count === e.count) else begin
            miscompares++;
            $error("[TB] FAIL %s.count observed=%0d expected=%0d", e.tag, count, e.count);
        end
        vectors++;
        assert (busy === e.busy) else begin
            miscompares++;
            $error("[TB] FAIL %s.busy observed=%0b expected=%0b", e.tag, busy, e.busy);
        end
        vectors++;
        assert (zero === ez) else begin
            miscompares++;
            $error("[TB] FAIL %s.zero observed=%0b expected=%0b", e.tag, zero, ez);
        end
        vectors++;
        assert (done === e.done) else begin
            miscompares++;
            $error("[TB] FAIL %s.done observed=%0b expected=%0b", e.tag, done, e.done);
        end
    endtask

    // One cycle: drive inputs, let the edge pass, then compare just after it.
    task automatic step(input string tag, input logic r, input logic [4:0] d,
                        input logic l, input logic s, input logic p, input logic sp,
                        input logic [4:0] ec, input logic eb, input logic ed);
        applyStimulus(tag, r, d, l, s, p, sp, ec, eb, ed);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1; data = 5'd0; load = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        #2;

        // tag          rst data ld st pa sp  count busy done
        step("reset",    1, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        step("idle",     0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);

        step("load5",    0, 5'd5, 1, 0, 0, 0, 5'd5, 0, 0);
        step("start5",   0, 5'd0, 0, 1, 0, 0, 5'd5, 1, 0);
        step("run4",     0, 5'd0, 0, 0, 0, 0, 5'd4, 1, 0);
        step("run3",     0, 5'd0, 0, 0, 0, 0, 5'd3, 1, 0);
        step("run2",     0, 5'd0, 0, 0, 0, 0, 5'd2, 1, 0);
        step("run1",     0, 5'd0, 0, 0, 0, 0, 5'd1, 1, 0);
        step("done5",    0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
`ifdef AUTO_RELOAD_EN
        step("after5",   0, 5'd0, 0, 0, 0, 0, 5'd5, 1, 0);
        step("stopAR",   0, 5'd0, 0, 0, 0, 1, 5'd5, 0, 0);
`else
        step("after5",   0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        step("stopIdle", 0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0);
`endif

        step("rstP",     1, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        step("load3",    0, 5'd3, 1, 0, 0, 0, 5'd3, 0, 0);
        step("start3",   0, 5'd0, 0, 1, 0, 0, 5'd3, 1, 0);
        step("p_run2",   0, 5'd0, 0, 0, 0, 0, 5'd2, 1, 0);
        step("pause1",   0, 5'd0, 0, 0, 1, 0, 5'd2, 1, 0);
        step("pause2",   0, 5'd0, 0, 0, 1, 0, 5'd2, 1, 0);
        step("p_run1",   0, 5'd0, 0, 0, 0, 0, 5'd1, 1, 0);
        step("p_done",   0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
`ifdef AUTO_RELOAD_EN
        step("p_after",  0, 5'd0, 0, 0, 0, 0, 5'd3, 1, 0);
`else
        step("p_after",  0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
`endif

        step("rstZ",     1, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        step("ldst0",    0, 5'd0, 1, 1, 0, 0, 5'd0, 0, 1);
        step("z_after",  0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        step("z_quiet",  0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        step("start0",   0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 1);
        step("s0_after", 0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);

        step("load6",    0, 5'd6, 1, 0, 0, 0, 5'd6, 0, 0);
        step("start6",   0, 5'd0, 0, 1, 0, 0, 5'd6, 1, 0);
        step("s_run5",   0, 5'd0, 0, 0, 0, 0, 5'd5, 1, 0);
        step("s_run4",   0, 5'd0, 0, 0, 0, 0, 5'd4, 1, 0);
        step("stopRun",  0, 5'd0, 0, 0, 0, 1, 5'd4, 0, 0);
        step("s_idle",   0, 5'd0, 0, 0, 0, 0, 5'd4, 0, 0);
        step("stopLoad", 0, 5'd9, 1, 0, 0, 1, 5'd4, 0, 0);
        step("restart4", 0, 5'd0, 0, 1, 0, 0, 5'd4, 1, 0);
        step("r_run3",   0, 5'd0, 0, 0, 0, 0, 5'd3, 1, 0);
        step("runLoad",  0, 5'd7, 1, 0, 1, 0, 5'd7, 1, 0);
        step("r_run6",   0, 5'd0, 0, 0, 0, 0, 5'd6, 1, 0);
        step("r_run5",   0, 5'd0, 0, 0, 0, 0, 5'd5, 1, 0);
        step("runLoad0", 0, 5'd0, 1, 0, 0, 0, 5'd0, 0, 1);
        step("rl_after", 0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);

        step("load2r",   0, 5'd2, 1, 0, 0, 0, 5'd2, 0, 0);
        step("start2r",  0, 5'd0, 0, 1, 0, 0, 5'd2, 1, 0);
        step("r_run1",   0, 5'd0, 0, 0, 0, 0, 5'd1, 1, 0);
        step("rstRun",   1, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        step("rst_quiet",0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);

        step("load2",    0, 5'd2, 1, 0, 0, 0, 5'd2, 0, 0);
        step("start2",   0, 5'd0, 0, 1, 0, 0, 5'd2, 1, 0);
        step("a_run1",   0, 5'd0, 0, 0, 0, 0, 5'd1, 1, 0);
        step("a_done1",  0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
`ifdef AUTO_RELOAD_EN
        step("a_run2b",  0, 5'd0, 0, 0, 0, 0, 5'd2, 1, 0);
        step("a_run1b",  0, 5'd0, 0, 0, 0, 0, 5'd1, 1, 0);
        step("a_done2",  0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
        step("a_run2c",  0, 5'd0, 0, 0, 0, 0, 5'd2, 1, 0);
        step("rstDone",  1, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
`else
        step("a_idle",   0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        step("a_quiet",  0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
        step("a_start0", 0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 1);
        step("rstDone",  1, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
`endif
        step("end_idle", 0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
